// File: rtl/htf_pkg.sv
// Shared types and constants for the horizontal twiddle-factor generator.
// Optional output register stage is enabled with `define HTF_OUT_REG_EN.
package htf_pkg;
  typedef enum logic [1:0] {HTF_IDLE, HTF_RUN, HTF_DONE} htf_state_e;

  localparam int HTF_P_WIDTH = 64;
  localparam int HTF_ROWS    = 4;
  localparam int HTF_DEPTH   = 64;
  localparam int HTF_IDX_W   = $clog2(HTF_DEPTH);
  localparam int HTF_ROW_W   = $clog2(HTF_ROWS);

  // Multiplicative identity; tables reset to this so an unloaded row is a no-op twiddle.
  localparam logic [HTF_P_WIDTH-1:0] HTF_ONE = HTF_P_WIDTH'(1);

  function automatic int htf_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/htf_row_table.sv
// One row's run-time-loadable factor table: single write port, combinational read.
module htf_row_table
  import htf_pkg::*;
#(
  parameter int P_WIDTH = HTF_P_WIDTH,
  parameter int DEPTH   = HTF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [htf_w(DEPTH)-1:0]  waddr,
  input  logic [P_WIDTH-1:0]       wdata,
  input  logic [htf_w(DEPTH)-1:0]  raddr,
  output logic [P_WIDTH-1:0]       rdata
);
  logic [P_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= P_WIDTH'(HTF_ONE);
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/htf_gen_multirow.sv
// Multi-row twiddle generator: FSM, index/hold counters and q register over ROWS tables.
// `define HTF_OUT_REG_EN adds a second q/q_valid register and delays done to match.
module htf_gen_multirow
  import htf_pkg::*;
#(
  parameter int P_WIDTH   = HTF_P_WIDTH,
  parameter int ROWS      = HTF_ROWS,
  parameter int DEPTH     = HTF_DEPTH,
  parameter int HOLD      = 16,
  parameter int SC_WIDTH  = 3,
  parameter int IDX_START = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      CEN,
  input  logic [SC_WIDTH-1:0]       stage_counter,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      wr_en,
  input  logic [htf_w(ROWS)-1:0]    wr_row,
  input  logic [htf_w(DEPTH)-1:0]   wr_addr,
  input  logic [P_WIDTH-1:0]        wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      q_valid,
  output logic [ROWS*P_WIDTH-1:0]   q,
  output logic                      wr_err
);
  localparam int IW = htf_w(DEPTH);
  localparam int RW = htf_w(ROWS);
  localparam int HW = htf_w(HOLD);

  htf_state_e state, state_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [HW-1:0] hold_cnt, hold_nx;
  logic en, load, wr_ok;
  logic [ROWS-1:0][P_WIDTH-1:0] rd, q_r;
  logic q_vld_r;

  assign en    = !CEN && (stage_counter == '0);
  assign load  = (state == HTF_RUN) && !CEN && !abort;
  assign wr_ok = wr_en && (state == HTF_IDLE);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    hold_nx  = hold_cnt;
    if (abort) begin
      state_nx = HTF_IDLE;
      idx_nx   = IW'(IDX_START);
      hold_nx  = '0;
    end else begin
      case (state)
        HTF_IDLE: if (start) begin
          state_nx = HTF_RUN;
          idx_nx   = IW'(IDX_START);
          hold_nx  = '0;
        end
        HTF_RUN: if (en) begin
          // HOLD is a power of 2, so the counter wraps on its own
          hold_nx = hold_cnt + 1'b1;
          if (hold_cnt == HW'(HOLD-1)) begin
            if (idx == IW'(DEPTH-1)) state_nx = HTF_DONE;
            else                     idx_nx   = idx + 1'b1;
          end
        end
        HTF_DONE: begin
          state_nx = HTF_IDLE;
          idx_nx   = IW'(IDX_START);
          hold_nx  = '0;
        end
        default: state_nx = HTF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HTF_IDLE;
      idx      <= IW'(IDX_START);
      hold_cnt <= '0;
      q_r      <= '0;
      q_vld_r  <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      hold_cnt <= hold_nx;
      if (load) q_r <= rd;
      if (state_nx == HTF_IDLE) q_vld_r <= 1'b0;
      else if (load)            q_vld_r <= 1'b1;
      if (wr_en && state != HTF_IDLE) wr_err <= 1'b1;
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    htf_row_table #(.P_WIDTH(P_WIDTH), .DEPTH(DEPTH)) u_tbl (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok && (wr_row == RW'(r))),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (idx),
      .rdata (rd[r])
    );
  end

  assign busy = (state == HTF_RUN);

`ifdef HTF_OUT_REG_EN
  logic [ROWS-1:0][P_WIDTH-1:0] q_p;
  logic vld_p, done_p;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_p    <= '0;
      vld_p  <= 1'b0;
      done_p <= 1'b0;
    end else begin
      q_p    <= q_r;
      vld_p  <= q_vld_r;
      done_p <= (state == HTF_DONE);
    end
  end
  assign q       = q_p;
  assign q_valid = vld_p;
  assign done    = done_p;
`else
  assign q       = q_r;
  assign q_valid = q_vld_r;
  assign done    = (state == HTF_DONE);
`endif
endmodule

// File: doc/htf_gen_multirow.md
# htf_gen_multirow

Parametrised horizontal twiddle-factor generator for the radix-16 NTT/FFT datapath: it drives ROWS butterfly rows in parallel, one P_WIDTH field element per row. Each row has its own run-time-loadable factor table, so the block is not tied to one transform size. A start/done handshake sequences the factor index, and each factor is held for HOLD enabled stage-0 cycles. It sits between the stage controller (state, stage_counter, CEN) and the per-row twiddle multipliers.

## Interface
- P_WIDTH, 64, field element width.
- ROWS, 4, number of butterfly rows (output lanes).
- DEPTH, 64, table entries per row (power of 2).
- HOLD, 16, enabled stage-0 cycles each factor is held (power of 2, ≥2).
- SC_WIDTH, 3, stage_counter width.
- IDX_START, 1, first index emitted after start.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- CEN  in  1  active-low clock-enable from the stage controller.
- stage_counter  in  SC_WIDTH  current stage; counters advance only when it is 0.
- start  in  1  one-cycle pulse that begins a sequence (accepted in IDLE only).
- abort  in  1  synchronous return to IDLE.
- wr_en  in  1  table write strobe.
- wr_row  in  clog2(ROWS)  table row to write.
- wr_addr  in  clog2(DEPTH)  table entry to write.
- wr_data  in  P_WIDTH  factor value to write.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at end of sequence.
- q_valid  out  1  q holds a valid factor.
- q  out  ROWS*P_WIDTH  row r occupies bits [r*P_WIDTH +: P_WIDTH].
- wr_err  out  1  sticky flag: a write arrived outside IDLE.

## Operation
- States are IDLE, RUN and DONE.
- IDLE → RUN on start; hold counter cleared; idx set to IDX_START.
- In RUN, with ~CEN and stage_counter==0, hold_cnt increments modulo HOLD.
- When hold_cnt==HOLD-1 (and the same condition holds), idx increments. Unlike the previous generation, idx never advances without enable.
- After the hold wrap at idx==DEPTH-1, the state goes to DONE and idx is not incremented. No wrap to 0.
- DONE → IDLE unconditionally after one cycle. done is high only in DONE.
- abort in any state → IDLE next cycle. Counters are cleared, q_valid drops, and q keeps its last value.
- q update: in RUN with ~CEN, every row r loads table[r][idx], whatever the stage. With CEN high, q and q_valid hold.
- q_valid: set on the first q load of a sequence; cleared on entering IDLE.
- Table writes take effect only in IDLE. A write in RUN or DONE is dropped and sets wr_err; only reset clears wr_err.
- start and abort in the same cycle: abort wins; start is ignored.
- start in RUN or DONE is ignored.
- wr_en and start in the same IDLE cycle: the write commits, and the first read sees the new value.
- Reset values:
  - state IDLE; idx=IDX_START; hold_cnt=0.
  - q=0; q_valid=0; busy=0; done=0; wr_err=0.
  - All table entries = 1 (multiplicative identity).
- Reset asserted mid-sequence: everything returns to the reset values immediately (asynchronous), and loaded table contents are lost.

## Timing
- start sampled at edge T: busy high after T.
- First q load is at edge T+1 if CEN is low during that cycle, so q_valid is seen high from T+1.
- Each idx is presented for exactly HOLD enabled stage-0 cycles. Cycles with stage_counter≠0 refresh q but do not count.
- Sequence length is (DEPTH-IDX_START)·HOLD enabled stage-0 cycles, then one DONE cycle.
- A table write at edge W is visible to reads from edge W+1.

## Configuration
- HTF_OUT_REG_EN defined: an extra register stage on q and q_valid for multiplier timing closure. Latency from idx change to q becomes 2 cycles; done is delayed by 1 cycle to stay aligned.
- Undefined: latency is 1 cycle as described above.

## Structure
- Package htf_pkg holds:
  - the state enum (HTF_IDLE, HTF_RUN, HTF_DONE);
  - index and row width localparams derived with clog2;
  - the identity constant (P_WIDTH'(1)).
- Sub-module htf_row_table: one instance per row. It has one write port, a combinational read at idx, and resets to identity. The top level holds the FSM, counters and output register.

## Test plan
- After reset, no writes: start with ~CEN held low and stage_counter=0. Expect every row q = 64'h1 from cycle T+1. done pulses after (64-1)·16 = 1008 stage-0 cycles; busy then falls.
- Load row 2 entry 1 = 64'h252502e45f699196 and entry 2 = 64'h08dda69734d315e3, then start. Expect row 2 to show the first value for 16 stage-0 cycles, then the second. Other rows stay 1.
- Toggle stage_counter to 3 for 5 cycles mid-hold. Expect idx frozen, the total hold still 16 stage-0 cycles, and q unchanged.
- Raise CEN for 10 cycles mid-run. Expect q, q_valid and the counters to hold; the sequence resumes exactly where it stopped.
- Write during RUN. Expect the table unchanged and wr_err=1. Then abort: IDLE next cycle, q_valid=0, and no done pulse.
- Assert rst_n low mid-run. Expect q=0 and state IDLE immediately, and the table back to 1.
